// File: rtl/scan_link_arbiter.sv
`timescale 1ns/1ps
// scan_link_arbiter
// Round-robin owner of the shared scanner transfer link. A grant is held
// until the owner pulses done, drops its request, or (optionally) times out.
// Optional feature macro: SCAN_LINK_TIMEOUT_EN enables the wait counter and
// the forced release with a timeout_err pulse. Without it the grant is only
// released by done or abort, and timeout_err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no grant; waits for link_enable and a request
// XFER     | link granted to o_owner
// RELEASE  | one-cycle gap, grant dropped, priority flipped
// 2'b11    | unreachable, recovers to IDLE
module scan_link_arbiter #(
  parameter int XFER_TIMEOUT = 15,
  parameter int CNT_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_link_enable,
  input  logic [1:0]       i_req,
  input  logic [1:0]       i_done,
  output logic [1:0]       o_gnt,
  output logic             o_owner,
  output logic             o_busy,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_xfer_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_XFER    = 2'b01,
    ST_RELEASE = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  state_t           r_state;
  logic [1:0]       r_gnt;
  logic             r_owner;
  logic             r_busy;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt;

  logic w_win;
  logic w_done_own;
  logic w_req_own;

  // Tie goes to the priority pointer; a lone requester always wins.
  assign w_win      = (i_req == 2'b11) ? r_prio : i_req[1];
  assign w_done_own = i_done[r_owner];
  assign w_req_own  = i_req[r_owner];

`ifdef SCAN_LINK_TIMEOUT_EN
  localparam logic [7:0] WAIT_TC = 8'(XFER_TIMEOUT - 1);

  logic [7:0] r_wait;
  logic       r_terr;

  // Wait counter and one-cycle timeout pulse; the pulse coincides with RELEASE.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wait <= 8'd0;
      r_terr <= 1'b0;
    end else begin
      r_terr <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_wait <= 8'd0;
      end else if (r_state == ST_XFER && !w_done_own && w_req_own) begin
        if (r_wait == WAIT_TC) begin
          r_terr <= 1'b1;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end
    end
  end

  logic w_timeout;
  assign w_timeout     = (r_wait == WAIT_TC);
  assign o_timeout_err = r_terr;
`else
  logic [7:0] w_unused_timeout;
  logic       w_timeout;
  assign w_unused_timeout = 8'(XFER_TIMEOUT);
  assign w_timeout        = 1'b0;
  assign o_timeout_err    = 1'b0;
`endif

  // Main arbitration FSM with registered grant, owner, busy and counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_owner <= 1'b0;
      r_busy  <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_link_enable && (i_req != 2'b00)) begin
            r_owner <= w_win;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // done beats abort beats timeout
          if (w_done_own || !w_req_own || w_timeout) begin
            if (w_done_own) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_prio  <= ~r_owner;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_owner    = r_owner;
  assign o_busy     = r_busy;
  assign o_xfer_cnt = r_cnt;
  assign o_state    = r_state;

endmodule

// File: doc/scan_link_arbiter.md
# scan_link_arbiter

Arbitrates the single shared transfer link between the two scanners of the scanner system. Each scanner raises a transfer request when its buffer is ready to move. The arbiter grants the link to exactly one scanner at a time, round-robin, and holds the grant until the owner reports completion, withdraws its request, or times out. It sits between the two scanner instances and the top-level LED/HEX outputs, and replaces the ad-hoc user-button transfer trigger.

## Interface

- XFER_TIMEOUT, 15 — cycles a grant may be held without `done` before forced release; legal range 1..255
- CNT_W, 8 — width of the completed-transfer counter
- clk  in  1  system clock (the divided scan clock at top level)
- reset  in  1  synchronous, active-low reset
- link_enable  in  1  system started; no new grant is issued while low
- req  in  2  per-scanner transfer request, level, held until granted and done
- done  in  2  per-scanner transfer complete, one-cycle pulse
- gnt  out  2  one-hot link grant, registered
- owner  out  1  index of the current grant holder; valid only while busy
- busy  out  1  link granted (state XFER)
- timeout_err  out  1  one-cycle pulse on forced release
- xfer_cnt  out  CNT_W  completed transfers, wraps modulo 2^CNT_W
- state  out  2  FSM encoding for HEX display

## Operation

- FSM states: IDLE=2'b00, XFER=2'b01, RELEASE=2'b10. 2'b11 is unreachable and recovers to IDLE.
- Transitions out of IDLE:
  - Condition: link_enable=1 and req!=0.
  - Winner: the only requester if one; if both, the scanner at priority pointer `prio`.
  - Action: latch owner, set gnt[owner], clear wait counter, go to XFER.
- Transitions out of XFER (evaluated in priority order):
  - done[owner]=1: increment xfer_cnt, go to RELEASE.
  - Else req[owner]=0 (abort): go to RELEASE, no increment, no error.
  - Else wait counter == XFER_TIMEOUT-1: go to RELEASE and flag timeout.
  - Otherwise: increment wait counter.
- Ignored inputs: done from the non-owner is ignored in every state; done in IDLE/RELEASE is ignored.
- RELEASE lasts exactly one cycle:
  - gnt=0; timeout_err=1 if flagged.
  - prio set to ~owner (the other scanner wins the next tie).
  - Return to IDLE.
- link_enable falling during XFER does not abort; the current transfer finishes normally.
- Wait counter is 8 bits and resets on every entry to XFER.

## Timing

- Reset (reset=0 at a clk edge): state=IDLE, gnt=0, owner=0, busy=0, timeout_err=0, xfer_cnt=0, prio=0, wait counter=0. Reset mid-transfer drops gnt on that same edge.
- Grant latency: req sampled at edge N in IDLE, gnt/busy high after edge N+1 (one cycle).
- Release latency: done sampled at edge M, gnt low after edge M+1. xfer_cnt updates on the same edge.
- Minimum gap between grants is one full cycle (RELEASE). Back-to-back grants alternate owner when both requests stay high.
- Timeout: with no done, gnt is held for exactly XFER_TIMEOUT cycles. timeout_err pulses in the cycle after gnt drops.
- done and timeout in the same cycle: done wins, count increments, no error.
- xfer_cnt wrap: at all-ones plus one completion it becomes 0, with no other side effect.

## Configuration

- SCAN_LINK_TIMEOUT_EN defined:
  - Wait counter and timeout release are implemented as above.
- Not defined:
  - XFER exits only on done or abort.
  - Wait counter is removed.
  - timeout_err is tied to 0.
  - XFER_TIMEOUT is unused.

## Test plan

- Single request: reset, link_enable=1, req=2'b01, done[0] after 3 cycles.
  - gnt=2'b01 one cycle after req, busy=1, owner=0.
  - gnt drops one cycle after done; xfer_cnt=1.
- Simultaneous requests: req=2'b11 held, each owner pulses done after 2 cycles of grant.
  - Grants go 01, 10, 01, each separated by one gnt=0 cycle.
  - xfer_cnt=3.
- Timeout (macro defined, XFER_TIMEOUT=4): req=2'b10, no done.
  - gnt=2'b10 for exactly 4 cycles.
  - timeout_err pulses once; xfer_cnt unchanged.
  - With the macro undefined, gnt is held indefinitely.
- Abort and stray done: owner 0 drops req mid-XFER while done[1] pulses.
  - Release with no count and no timeout_err.
  - done[1] is ignored.
- link_enable and reset: link_enable=0 with req=2'b11 produces no grant.
  - With link_enable dropped mid-XFER, the transfer completes.
  - reset=0 mid-XFER clears gnt, busy and xfer_cnt on that edge.
- Wrap: CNT_W=2 with 5 completions gives xfer_cnt=1.
